// File: rtl/alu_if.sv
// alu_if: operand/command and registered result/flag bundle between the datapath and the ALU.
interface alu_if #(parameter int WIDTH = 32);
    logic [WIDTH-1:0] operandA;
    logic [WIDTH-1:0] operandB;
    logic [2:0]       command;
    logic [WIDTH-1:0] result;
    logic             carryout;
    logic             zero;
    logic             overflow;
    modport master (output operandA, operandB, command, input result, carryout, zero, overflow);
    modport slave  (input operandA, operandB, command, output result, carryout, zero, overflow);
endinterface

// File: rtl/alu.sv
// alu: registered 32-bit ALU (add, sub, xor, slt, and, nand, nor, or) with carry/zero/overflow flags.
module alu #(parameter int WIDTH = 32) (
    input  logic clk,
    input  logic reset,
    alu_if.slave bus
);
    localparam logic [2:0] ADD = 3'd0, SUB = 3'd1, XOR = 3'd2, SLT = 3'd3;
    localparam logic [2:0] AND = 3'd4, NAND = 3'd5, NOR = 3'd6;
    logic [WIDTH-1:0] w_a, w_b, w_binv, w_res;
    logic [WIDTH:0]   w_sum;
    logic             w_arith, w_ovf, w_slt;
    logic [WIDTH-1:0] r_result;
    logic             r_carry, r_zero, r_ovf;
    assign w_a     = bus.operandA;
    assign w_b     = bus.operandB;
    assign w_arith = bus.command == ADD || bus.command == SUB;
    // SUB and SLT share one adder: A + ~B + 1
    assign w_binv  = bus.command == ADD ? w_b : ~w_b;
    assign w_sum   = {1'b0, w_a} + {1'b0, w_binv} + {{WIDTH{1'b0}}, bus.command != ADD};
    assign w_ovf   = (w_a[WIDTH-1] == w_binv[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
    assign w_slt   = w_sum[WIDTH-1] ^ w_ovf;
    always_comb begin
        w_res = bus.command == ADD  ? w_sum[WIDTH-1:0] :
                bus.command == SUB  ? w_sum[WIDTH-1:0] :
                bus.command == XOR  ? w_a ^ w_b :
                bus.command == SLT  ? {{(WIDTH-1){1'b0}}, w_slt} :
                bus.command == AND  ? w_a & w_b :
                bus.command == NAND ? ~(w_a & w_b) :
                bus.command == NOR  ? ~(w_a | w_b) :
                                      w_a | w_b;
    end
    always_ff @(posedge clk) begin
        if (reset) begin
            r_result <= '0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
            r_ovf    <= 1'b0;
        end else begin
            r_result <= w_res;
            r_carry  <= w_arith & w_sum[WIDTH];
            r_zero   <= ~|w_res;
            r_ovf    <= w_arith & w_ovf;
        end
    end
    assign bus.result   = r_result;
    assign bus.carryout = r_carry;
    assign bus.zero     = r_zero;
    assign bus.overflow = r_ovf;
endmodule

// File: tb/tb_alu.sv
// tb_alu: directed-vector self-checking bench for the registered ALU.
module tb_alu;
    logic clk = 1'b0;
    logic reset = 1'b1;
    int checks = 0;
    int failures = 0;
    alu_if #(.WIDTH(32)) bus ();
    alu #(.WIDTH(32)) dut (.clk(clk), .reset(reset), .bus(bus));
    always #5 clk = ~clk;

    // drive inputs just after an edge, then step past the next edge
    task automatic apply(input logic [31:0] a, input logic [31:0] b, input logic [2:0] c);
        bus.operandA = a;
        bus.operandB = b;
        bus.command  = c;
        @(posedge clk);
        #1;
    endtask

    function automatic logic [34:0] obs();
        return {bus.result, bus.carryout, bus.zero, bus.overflow};
    endfunction

    task automatic test_reset();
        reset = 1'b1;
        apply(32'hFFFF_FFFF, 32'h1234_5678, 3'd0);
        checks++;
        if (obs() !== {32'h0, 3'b010}) begin
            failures++;
            $display("FAIL reset got=%h exp=%h", obs(), {32'h0, 3'b010});
        end
        reset = 1'b0;
        apply(32'h000A_0000, 32'h0000_0070, 3'd0);
        checks++;
        if (obs() !== {32'h000A_0070, 3'b000}) begin
            failures++;
            $display("FAIL first_add got=%h exp=%h", obs(), {32'h000A_0070, 3'b000});
        end
    endtask

    task automatic run_vecs(input string name, input logic [31:0] a[], input logic [31:0] b[],
                            input logic [2:0] c, input logic [34:0] e[]);
        for (int i = 0; i < a.size(); i++) begin
            apply(a[i], b[i], c);
            checks++;
            if (obs() !== e[i]) begin
                failures++;
                $display("FAIL %s[%0d] A=%h B=%h got=%h exp=%h", name, i, a[i], b[i], obs(), e[i]);
            end
        end
    endtask

    task automatic test_add();
        logic [31:0] a[] = '{32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        logic [31:0] b[] = '{32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
        logic [34:0] e[] = '{{32'hFFFF_FFFE, 3'b001}, {32'h0, 3'b110}, {32'h0, 3'b111}};
        run_vecs("add", a, b, 3'd0, e);
    endtask

    task automatic test_sub();
        logic [31:0] a[] = '{32'h000A_0000, 32'h7FFF_FFFF, 32'h0000_0001, 32'h8000_0000};
        logic [31:0] b[] = '{32'hFFFF_FF90, 32'h8000_0001, 32'h0000_0001, 32'h7000_0000};
        logic [34:0] e[] = '{{32'h000A_0070, 3'b000}, {32'hFFFF_FFFE, 3'b001},
                             {32'h0, 3'b110}, {32'h1000_0000, 3'b101}};
        run_vecs("sub", a, b, 3'd1, e);
    endtask

    task automatic test_slt();
        logic [31:0] a[] = '{32'h1, 32'h7FFF_FFFF, 32'h1, 32'h8000_0000, 32'hF000_0000,
                             32'h8000_0000, 32'h0500_0000, 32'h0};
        logic [31:0] b[] = '{32'h0500_0000, 32'h8000_0001, 32'h1, 32'hF000_0000, 32'h8000_0000,
                             32'h0500_0000, 32'h8000_0000, 32'h0};
        logic [34:0] e[] = '{{32'h1, 3'b000}, {32'h0, 3'b010}, {32'h0, 3'b010}, {32'h1, 3'b000},
                             {32'h0, 3'b010}, {32'h1, 3'b000}, {32'h0, 3'b010}, {32'h0, 3'b010}};
        run_vecs("slt", a, b, 3'd3, e);
    endtask

    task automatic test_logic();
        logic [31:0] a[] = '{32'h8888_8888, 32'hCCCC_CCCC, 32'hBBBB_BBBB};
        logic [31:0] b[] = '{32'h1111_1111, 32'hCCCC_CCCC, 32'h5555_5555};
        logic [34:0] ex[] = '{{32'h9999_9999, 3'b000}, {32'h0, 3'b010}, {32'hEEEE_EEEE, 3'b000}};
        logic [34:0] ea[] = '{{32'h0, 3'b010}, {32'hCCCC_CCCC, 3'b000}, {32'h1111_1111, 3'b000}};
        logic [34:0] en[] = '{{32'hFFFF_FFFF, 3'b000}, {32'h3333_3333, 3'b000}, {32'hEEEE_EEEE, 3'b000}};
        logic [34:0] er[] = '{{32'h6666_6666, 3'b000}, {32'h3333_3333, 3'b000}, {32'h0, 3'b010}};
        logic [34:0] eo[] = '{{32'h9999_9999, 3'b000}, {32'hCCCC_CCCC, 3'b000}, {32'hFFFF_FFFF, 3'b000}};
        run_vecs("xor", a, b, 3'd2, ex);
        run_vecs("and", a, b, 3'd4, ea);
        run_vecs("nand", a, b, 3'd5, en);
        run_vecs("nor", a, b, 3'd6, er);
        run_vecs("or", a, b, 3'd7, eo);
    endtask

    task automatic test_back_to_back();
        logic [31:0] a[] = '{32'h7FFF_FFFF, 32'h8000_0000, 32'hCCCC_CCCC, 32'h0000_0005, 32'h1, 32'h0000_0003};
        logic [31:0] b[] = '{32'h0000_0001, 32'h0000_0001, 32'h3333_3333, 32'h0000_0009, 32'h1, 32'h0000_0004};
        logic [2:0]  c[] = '{3'd0, 3'd1, 3'd6, 3'd3, 3'd2, 3'd7};
        logic        r[] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        logic [34:0] e[] = '{{32'h8000_0000, 3'b001}, {32'h7FFF_FFFF, 3'b101}, {32'h0, 3'b010},
                             {32'h0, 3'b010}, {32'h0, 3'b010}, {32'h7, 3'b000}};
        logic [34:0] prev;
        for (int i = 0; i < a.size(); i++) begin
            prev = obs();
            reset = r[i];
            bus.operandA = a[i];
            bus.operandB = b[i];
            bus.command  = c[i];
            #3;
            checks++;
            if (obs() !== prev) begin
                failures++;
                $display("FAIL b2b_hold[%0d] got=%h exp=%h", i, obs(), prev);
            end
            @(posedge clk);
            #1;
            checks++;
            if (obs() !== e[i]) begin
                failures++;
                $display("FAIL b2b[%0d] got=%h exp=%h", i, obs(), e[i]);
            end
        end
        reset = 1'b0;
    endtask

    initial begin
        bus.operandA = '0;
        bus.operandB = '0;
        bus.command  = '0;
        @(posedge clk);
        #1;
        test_reset();
        test_add();
        test_sub();
        test_slt();
        test_logic();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
